// File: rtl/priority_resolver_gen.sv
// Rotating-priority interrupt resolver with IRR/ISR state, acknowledge handshake,
// specific/non-specific EOI, auto-EOI and programmable lowest-priority pointer.
module priority_resolver_gen #(
  parameter int NUM_IRQ  = 8,
  parameter int ID_WIDTH = 3
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NUM_IRQ-1:0]  irq_in,
  input  logic                level_triggered,
  input  logic [NUM_IRQ-1:0]  interrupt_mask,
  input  logic                special_mask_mode,
  input  logic                auto_eoi,
  input  logic                rotate_on_eoi,
  input  logic                inta,
  input  logic                eoi_valid,
  input  logic                eoi_specific,
  input  logic [ID_WIDTH-1:0] eoi_level,
  input  logic                set_priority_valid,
  input  logic [ID_WIDTH-1:0] set_priority_level,
  output logic                int_out,
  output logic                vector_valid,
  output logic [ID_WIDTH-1:0] vector_id,
  output logic                spurious,
  output logic [NUM_IRQ-1:0]  interrupt_request_register,
  output logic [NUM_IRQ-1:0]  in_service_register
);

  logic [NUM_IRQ-1:0]  irq_prev;
  logic [ID_WIDTH-1:0] lowest_priority;

  logic [NUM_IRQ-1:0]  pending;
  logic [ID_WIDTH-1:0] scan_idx;
  logic                win_found;
  logic [ID_WIDTH-1:0] win_id;
  logic [ID_WIDTH-1:0] win_rank;
  logic                isr_found;
  logic [ID_WIDTH-1:0] isr_id;
  logic [ID_WIDTH-1:0] isr_rank;

  logic                ack;
  logic [NUM_IRQ-1:0]  ack_onehot;
  logic                eoi_hit;
  logic [ID_WIDTH-1:0] eoi_id;
  logic [NUM_IRQ-1:0]  eoi_onehot;
  logic                raise;
  logic [NUM_IRQ-1:0]  irr_next;
  logic [NUM_IRQ-1:0]  isr_next;

  assign pending = interrupt_request_register & ~interrupt_mask;

  // Rank k = distance from the highest-priority slot (lowest_priority + 1).
  always_comb begin
    scan_idx  = '0;
    win_found = 1'b0;
    win_id    = '0;
    win_rank  = '0;
    isr_found = 1'b0;
    isr_id    = '0;
    isr_rank  = '1;
    for (int unsigned k = 0; k < NUM_IRQ; k++) begin
      scan_idx = lowest_priority + ID_WIDTH'(k + 32'd1);
      if (!win_found && pending[scan_idx]) begin
        win_found = 1'b1;
        win_id    = scan_idx;
        win_rank  = ID_WIDTH'(k);
      end
      if (!isr_found && in_service_register[scan_idx]) begin
        isr_found = 1'b1;
        isr_id    = scan_idx;
        isr_rank  = ID_WIDTH'(k);
      end
    end
  end

  always_comb begin
    ack        = inta && int_out && win_found;
    ack_onehot = '0;
    if (ack)
      ack_onehot[win_id] = 1'b1;

    eoi_id     = eoi_specific ? eoi_level : isr_id;
    eoi_hit    = eoi_valid && (eoi_specific ? in_service_register[eoi_level] : isr_found);
    eoi_onehot = '0;
    if (eoi_hit)
      eoi_onehot[eoi_id] = 1'b1;

    raise = win_found && (!isr_found || special_mask_mode || (win_rank < isr_rank));

    if (level_triggered)
      irr_next = irq_in;
    else
      irr_next = interrupt_request_register | (irq_in & ~irq_prev);
    irr_next = irr_next & ~ack_onehot;

    // EOI works on the pre-edge ISR; a same-cycle acknowledge still sets its bit.
    isr_next = (in_service_register & ~eoi_onehot) | (auto_eoi ? '0 : ack_onehot);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      irq_prev                   <= '0;
      lowest_priority            <= '1;
      interrupt_request_register <= '0;
      in_service_register        <= '0;
      int_out                    <= 1'b0;
      vector_valid               <= 1'b0;
      vector_id                  <= '0;
      spurious                   <= 1'b0;
    end else begin
      irq_prev                   <= irq_in;
      interrupt_request_register <= irr_next;
      in_service_register        <= isr_next;

      if (set_priority_valid)
        lowest_priority <= set_priority_level;
      else if (rotate_on_eoi && eoi_hit)
        lowest_priority <= eoi_id;
      else if (rotate_on_eoi && auto_eoi && ack)
        lowest_priority <= win_id;

      int_out      <= inta ? 1'b0 : raise;
      vector_valid <= inta;
      if (inta) begin
        vector_id <= ack ? win_id : '1;
        spurious  <= !ack;
      end else begin
        spurious  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_priority_resolver_gen.sv
// Bench for priority_resolver_gen: directed scenarios then random traffic, with
// 8- and 16-channel instances checked every cycle against a behavioural model.
module tb_priority_resolver_gen;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] irq = '0;
  logic [15:0] mask = '0;
  logic        lvl_mode = 1'b0, smm = 1'b0, aeoi = 1'b0, rot = 1'b0;
  logic        inta = 1'b0, eoi_v = 1'b0, eoi_s = 1'b0, setp_v = 1'b0;
  logic [3:0]  eoi_l = '0, setp_l = '0;

  logic        int8, vv8, spur8;
  logic [2:0]  vid8;
  logic [7:0]  irr8, isr8;
  logic        int16, vv16, spur16;
  logic [3:0]  vid16;
  logic [15:0] irr16, isr16;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  priority_resolver_gen #(.NUM_IRQ(8), .ID_WIDTH(3)) dut8 (
    .clock(clock), .reset_n(reset_n), .irq_in(irq[7:0]), .level_triggered(lvl_mode),
    .interrupt_mask(mask[7:0]), .special_mask_mode(smm), .auto_eoi(aeoi),
    .rotate_on_eoi(rot), .inta(inta), .eoi_valid(eoi_v), .eoi_specific(eoi_s),
    .eoi_level(eoi_l[2:0]), .set_priority_valid(setp_v), .set_priority_level(setp_l[2:0]),
    .int_out(int8), .vector_valid(vv8), .vector_id(vid8), .spurious(spur8),
    .interrupt_request_register(irr8), .in_service_register(isr8));

  priority_resolver_gen #(.NUM_IRQ(16), .ID_WIDTH(4)) dut16 (
    .clock(clock), .reset_n(reset_n), .irq_in(irq), .level_triggered(lvl_mode),
    .interrupt_mask(mask), .special_mask_mode(smm), .auto_eoi(aeoi),
    .rotate_on_eoi(rot), .inta(inta), .eoi_valid(eoi_v), .eoi_specific(eoi_s),
    .eoi_level(eoi_l), .set_priority_valid(setp_v), .set_priority_level(setp_l),
    .int_out(int16), .vector_valid(vv16), .vector_id(vid16), .spurious(spur16),
    .interrupt_request_register(irr16), .in_service_register(isr16));

  // Reference model, index 0 = 8 channels, index 1 = 16 channels.
  int          nn[2] = '{8, 16};
  logic [31:0] m_irr[2], m_isr[2], m_prev[2];
  int          m_lp[2], m_vid[2];
  logic        m_int[2], m_vv[2], m_spur[2];

  // Channel of highest priority set in s, or -1; priority starts at lp+1 and wraps.
  function automatic int top_of(logic [31:0] s, int lp, int n);
    for (int k = 0; k < n; k++)
      if (s[(lp + 1 + k) % n]) return (lp + 1 + k) % n;
    return -1;
  endfunction

  function automatic int rank_of(int c, int lp, int n);
    return (c - lp - 1 + 2 * n) % n;
  endfunction

  task automatic model_step(int j);
    int n, w, iw, t, le, lpv;
    logic [31:0] msk, in_irq, pend, nirr, nisr;
    logic raise, ack;
    n      = nn[j];
    msk    = (32'd1 << n) - 32'd1;
    in_irq = 32'(irq) & msk;
    pend   = m_irr[j] & ~(32'(mask) & msk);
    le     = int'(eoi_l) % n;
    lpv    = int'(setp_l) % n;
    w      = top_of(pend, m_lp[j], n);
    iw     = top_of(m_isr[j], m_lp[j], n);
    raise  = (w >= 0) && (m_isr[j] == 0 || smm ||
             rank_of(w, m_lp[j], n) < rank_of(iw, m_lp[j], n));
    ack    = inta && m_int[j] && (w >= 0);
    t = -1;
    if (eoi_v) begin
      if (eoi_s) begin
        if (m_isr[j][le]) t = le;
      end else begin
        t = iw;
      end
    end
    nirr = lvl_mode ? in_irq : (m_irr[j] | (in_irq & ~m_prev[j]));
    if (ack) nirr[w] = 1'b0;
    nisr = m_isr[j];
    if (t >= 0) nisr[t] = 1'b0;
    if (ack && !aeoi) nisr[w] = 1'b1;
    if (setp_v) m_lp[j] = lpv;
    else if (rot && t >= 0) m_lp[j] = t;
    else if (rot && aeoi && ack) m_lp[j] = w;
    m_irr[j]  = nirr;
    m_isr[j]  = nisr;
    m_prev[j] = in_irq;
    m_int[j]  = !inta && raise;
    m_vv[j]   = inta;
    if (inta) begin
      m_vid[j]  = ack ? w : n - 1;
      m_spur[j] = !ack;
    end else begin
      m_spur[j] = 1'b0;
    end
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j < 2; j++) begin
        m_irr[j] = '0; m_isr[j] = '0; m_prev[j] = '0;
        m_lp[j] = nn[j] - 1; m_vid[j] = 0;
        m_int[j] = 1'b0; m_vv[j] = 1'b0; m_spur[j] = 1'b0;
      end
    end else begin
      for (int j = 0; j < 2; j++) model_step(j);
    end
  end

  task automatic chk(string tag, int n, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s n=%0d observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] o_int, o_vec, o_irr, o_isr, e_vec;
    for (int j = 0; j < 2; j++) begin
      o_int = (j == 0) ? 32'(int8) : 32'(int16);
      o_vec = (j == 0) ? (32'(vid8) | (32'(spur8) << 16) | (32'(vv8) << 17))
                       : (32'(vid16) | (32'(spur16) << 16) | (32'(vv16) << 17));
      o_irr = (j == 0) ? 32'(irr8) : 32'(irr16);
      o_isr = (j == 0) ? 32'(isr8) : 32'(isr16);
      e_vec = 32'(m_vid[j]) | (32'(m_spur[j]) << 16) | (32'(m_vv[j]) << 17);
      chk("int_out", nn[j], o_int, 32'(m_int[j]));
      chk("vector", nn[j], o_vec, e_vec);
      chk("irr", nn[j], o_irr, m_irr[j]);
      chk("isr", nn[j], o_isr, m_isr[j]);
    end
  endtask

  task automatic tick(int cycles = 1);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clock);
      #1;
      check_all();
    end
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_int", 8, 32'(int8), 0);
    chk("rst_irr", 8, 32'(irr8), 0);
    tick(2);
    reset_n = 1'b1;
    tick();

    // Edge mode, three requests; channel 0 wins
    irq = 16'h0091;
    tick();
    chk("s1_irr", 8, 32'(irr8), 32'h91);
    tick();
    chk("s1_int", 8, 32'(int8), 1);
    inta = 1'b1; tick(); inta = 1'b0;
    chk("s1_vid", 8, 32'(vid8), 0);
    chk("s1_vv", 8, 32'(vv8), 1);
    chk("s1_isr", 8, 32'(isr8), 32'h01);

    // Nested: channel 4 blocked by ISR[0] until non-specific EOI
    tick(2);
    chk("s2_blocked", 8, 32'(int8), 0);
    eoi_v = 1'b1; tick(); eoi_v = 1'b0;
    tick();
    chk("s2_int", 8, 32'(int8), 1);
    inta = 1'b1; tick(); inta = 1'b0;
    chk("s2_vid", 8, 32'(vid8), 4);

    // Rotate on specific EOI of channel 4
    rot = 1'b1; eoi_v = 1'b1; eoi_s = 1'b1; eoi_l = 4'd4;
    tick();
    eoi_v = 1'b0; eoi_s = 1'b0;
    irq = '0; tick();
    irq = 16'h0092; tick(3);
    chk("s3_irr", 8, 32'(irr8), 32'h92);
    inta = 1'b1; tick(); inta = 1'b0;
    chk("s3_vid", 8, 32'(vid8), 7);
    chk("s3_spur", 8, 32'(spur8), 0);
    eoi_v = 1'b1; tick(); eoi_v = 1'b0;

    // Specific rotation to lowest=1, then a spurious acknowledge
    setp_v = 1'b1; setp_l = 4'd1; tick(); setp_v = 1'b0;
    irq = '0; tick();
    irq = 16'h009A; tick(2);
    chk("s4_irr", 8, 32'(irr8), 32'h9A);
    inta = 1'b1; tick();
    chk("s4_vid", 8, 32'(vid8), 3);
    tick(); inta = 1'b0;
    chk("s4_spur_vid", 8, 32'(vid8), 7);
    chk("s4_spur", 8, 32'(spur8), 1);
    chk("s4_spur_isr", 8, 32'(isr8), 32'h08);
    eoi_v = 1'b1; tick(); eoi_v = 1'b0;
    rot = 1'b0;

    // Auto-EOI in level mode
    lvl_mode = 1'b1; aeoi = 1'b1; irq = 16'h0020;
    tick(2);
    inta = 1'b1; tick(); inta = 1'b0;
    chk("s5_vid", 8, 32'(vid8), 5);
    chk("s5_isr", 8, 32'(isr8), 0);
    tick();
    chk("s5_irr", 8, 32'(irr8), 32'h20);

    // Special mask mode lets channel 5 through past ISR[0]
    aeoi = 1'b0; irq = 16'h0001;
    setp_v = 1'b1; setp_l = 4'd7; tick(); setp_v = 1'b0;
    tick(2);
    inta = 1'b1; tick(); inta = 1'b0;
    chk("s5_isr0", 8, 32'(isr8), 32'h01);
    irq = 16'h0020; tick(3);
    chk("s5_nosmm", 8, 32'(int8), 0);
    smm = 1'b1; tick();
    chk("s5_smm", 8, 32'(int8), 1);

    // Reset mid-handshake, line held high through release
    smm = 1'b0; lvl_mode = 1'b0; irq = 16'h00FF; inta = 1'b1;
    #3 reset_n = 1'b0;
    #1;
    chk("s6_int", 8, 32'(int8), 0);
    chk("s6_vv", 8, 32'(vv8), 0);
    chk("s6_isr", 8, 32'(isr8), 0);
    chk("s6_isr16", 16, 32'(isr16), 0);
    inta = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick();
    chk("s6_irr", 8, 32'(irr8), 32'hFF);
    chk("s6_novv", 8, 32'(vv8), 0);
    tick();
    inta = 1'b1; tick(); inta = 1'b0;
    chk("s6_vid", 8, 32'(vid8), 0);
    chk("s6_vid16", 16, 32'(vid16), 0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      irq    = 16'($urandom & $urandom);
      mask   = ($urandom_range(0, 3) == 0) ? 16'($urandom) : '0;
      if ($urandom_range(0, 31) == 0) lvl_mode = ~lvl_mode;
      if ($urandom_range(0, 15) == 0) smm = ~smm;
      if ($urandom_range(0, 15) == 0) aeoi = ~aeoi;
      if ($urandom_range(0, 15) == 0) rot = ~rot;
      inta   = ($urandom_range(0, 3) == 0);
      eoi_v  = ($urandom_range(0, 5) == 0);
      eoi_s  = 1'($urandom);
      eoi_l  = 4'($urandom);
      setp_v = ($urandom_range(0, 15) == 0);
      setp_l = 4'($urandom);
      if ($urandom_range(0, 99) == 0) reset_n = 1'b0;
      else reset_n = 1'b1;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
